rr_decode_arbiter: RTL

//  Round-robin arbiter that shares one decoded select resource among up to 16 requesters.

---
 rtl/rr_arb_pkg.sv | 13 +
 rtl/arb_idx_decoder.sv | 22 ++
 rtl/rr_decode_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin decode arbiter.
//   arb_state_t : arbiter FSM state (idle / grant held)
//   MAX_REQ     : largest supported requester count
package rr_arb_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : rr_arb_pkg

// File: rtl/arb_idx_decoder.sv
// Enabled binary-to-one-hot decoder, purely combinational.
// Ports:
//   idx      in  IDX_W       binary index to decode
//   en       in  1           when low the output is all zero
//   onehot_c out 2**IDX_W    one-hot decode of idx, gated by en
module arb_idx_decoder #(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [(2**IDX_W)-1:0] onehot_c
);

    // Decode with enable gating.
    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[idx] = 1'b1;
        end
    end

endmodule : arb_idx_decoder

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoded select resource among N_REQ requesters.
// A winner is held until it drops its request; on every hand-off the previous
// owner becomes lowest priority. The winner index drives a one-hot decoder.
// Optional build macro ARB_HOLD_LIMIT_EN: force a hand-off once an owner has
// reached HOLD_MAX on its hold counter while anyone else is requesting.
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   req      in   N_REQ  level request vector
//   gnt      out  N_REQ  one-hot grant, zero when gnt_vld=0 (decoded from registers)
//   gnt_idx  out  IDX_W  current owner index, zero when idle (registered)
//   gnt_vld  out  1      grant active (registered)
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned IDX_W    = $clog2(N_REQ),
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             hold_hit;
    logic             new_grant;

    // While granting, search starts just above the owner and excludes it,
    // so the owner is always the lowest priority at hand-off time.
    always_comb begin
        owner_oh = N_REQ'(1) << idx_q;
        if (state_q == ST_GRANT) begin
            base = idx_q + IDX_W'(1);
            cand = req & ~owner_oh;
        end else begin
            base = ptr_q;
            cand = req;
        end
    end

    // First set candidate scanning upward from base; IDX_W-bit add wraps mod N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && cand[base + IDX_W'(k)]) begin
                found = 1'b1;
                win   = base + IDX_W'(k);
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign hold_hit = (hold_q == HOLD_W'(HOLD_MAX));

    // Grant-cycle counter of the current owner, saturating, cleared on each new grant.
    always_comb begin
        hold_d = hold_q;
        if (new_grant) begin
            hold_d = '0;
        end else if (vld_q && !hold_hit) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // HOLD_MAX only matters when the hold limit is built in.
    localparam int unsigned unused_hold_max = HOLD_MAX;

    assign hold_hit = 1'b0;
`endif

    // Next-state and register updates for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d   = ST_GRANT;
                    idx_d     = win;
                    vld_d     = 1'b1;
                    new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                // Release, or forced hand-off when someone else is waiting.
                if (!req[idx_q] || (hold_hit && found)) begin
                    ptr_d = idx_q + IDX_W'(1);
                    if (found) begin
                        idx_d     = win;
                        new_grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;

    arb_idx_decoder #(
        .IDX_W (IDX_W)
    ) u_dec (
        .idx      (idx_q),
        .en       (vld_q),
        .onehot_c (gnt)
    );

endmodule : rr_decode_arbiter
